dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the MEM stage: accepts loads/stores from the pipeline, applies byte-lane
//  write enables (0001 sb, 0011 sh, 1111 sw), aligns lanes by addr[1:0], sign/zero-extends load data.
//  Inserts WAIT_STATES wait cycles per access and stalls the pipeline via stall_o. Sits beside control_path.
// PARAMETERS
//  DEPTH        1024  memory size in 32-bit words (power of two)
//  WAIT_STATES  0     extra busy cycles per access (0..15); 0 = single-cycle response
// PORTS
//  clk            in   1   clock; all state on posedge
//  rst_n          in   1   reset, synchronous, ACTIVE-HIGH (resets when 1)
//  addr_i         in   32  byte address of access
//  data_mem_we_i  in   4   unshifted byte enables from control path; nonzero = store
//  re_i           in   1   load request
//  funct3_i       in   3   load type (LB/LH/LW/LBU/LHU)
//  wdata_i        in   32  store data, right-justified
//  rdata_o        out  32  extended load data; valid when ready_o=1
//  ready_o        out  1   one-cycle pulse: access complete
//  stall_o        out  1   hold PC, IF/ID, ID/EX, EX/MEM while 1
//  misalign_o     out  1   only with DMEM_MISALIGN_TRAP_EN: access was misaligned
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, rdata_o=0, ready_o=0, stall_o=0, misalign_o=0; RAM not cleared.
//  - req = re_i | (|data_mem_we_i). Initiator holds all inputs stable while stall_o=1.
//  - FSM: IDLE -req & WAIT_STATES>0-> BUSY (cnt=WAIT_STATES-1); IDLE -req & WAIT_STATES==0-> RESP;
//    BUSY -cnt==0-> RESP, else cnt--; RESP -> IDLE unconditionally (a new req is taken next cycle).
//  - stall_o = (IDLE & req) | BUSY; 0 in RESP. ready_o = 1 only in RESP. Latency req->ready_o = WAIT_STATES+1.
//  - Word index = addr_i[log2(DEPTH)+1:2]; higher address bits ignored (aliasing wrap-around).
//  - Store: lanes = (we << addr[1:0]) truncated to 4 bits; data = wdata_i << 8*addr[1:0]; write in RESP cycle.
//  - Load: word read registered; rdata_o loaded in RESP, held until next RESP.
//    LB/LBU byte at addr[1:0]; LH/LHU half at addr[1]; LW full word; 000/001 sign-, 100/101 zero-extend;
//    funct3 010/011/110/111 treated as LW.
//  - re_i and store together: store wins; rdata_o = pre-write word, extended per funct3_i.
//  - Reset mid-access (BUSY/RESP): return to IDLE; pending store dropped, RAM unmodified.
//  - Misaligned = sh at addr[1:0]==3, sw at addr[1:0]!=0, LH/LHU at addr[0]==1, LW at addr[1:0]!=0.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined: misalign_o exists and pulses with ready_o on misaligned access;
//    the store is suppressed (no lane written) and rdata_o=0 for that access.
//  Not defined: no misalign_o port; misaligned stores write only lanes that fit (shifted-out
//    lanes dropped); misaligned loads extract from the addressed word without crossing words.
// STRUCTURE
//  Package dmem_pkg: FSM state encoding (IDLE/BUSY/RESP), funct3 load codes, byte-enable codes
//    (WE_SB=4'b0001, WE_SH=4'b0011, WE_SW=4'b1111).
//  Sub-module dmem_lane_align: combinational store-lane shifter, load extractor/extender, misalign detect.
//  Top keeps the FSM, wait counter, RAM array and output registers.
// TESTING
//  1 WAIT_STATES=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> ready_o 1 cycle after each req, rdata_o=0xDEADBEEF.
//  2 sb 0x000000AA @0x13 over 0x11223344 -> word 0xAA223344; lb @0x13 -> 0xFFFFFFAA; lbu -> 0x000000AA.
//  3 sh 0x8001 @0x22 over 0 -> word 0x80010000; lh @0x22 -> 0xFFFF8001; lhu -> 0x00008001.
//  4 WAIT_STATES=3: lw req -> stall_o=1 four cycles, ready_o on cycle 4, stall_o=0 that cycle.
//  5 Reset asserted in BUSY of a sw 0x55555555 @0x40 -> IDLE next cycle, outputs 0, word @0x40 unchanged.
//  6 sw @0x42 with DMEM_MISALIGN_TRAP_EN -> misalign_o=1 with ready_o, memory unchanged; without macro ->
//    lanes 2,3 written with wdata_i[15:0].

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: FSM states, load funct3 codes
// and the unshifted byte-enable codes driven by the control path.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] WE_SB = 4'b0001;
    localparam logic [3:0] WE_SH = 4'b0011;
    localparam logic [3:0] WE_SW = 4'b1111;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store lane/data shift, load extract/extend,
// and misalignment detect when DMEM_MISALIGN_TRAP_EN is defined.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_lanes,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    input  logic        i_re,
    output logic        o_misalign
`endif
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // 4-bit result width drops lanes shifted past byte 3.
    assign o_lanes = i_we << i_off;
    assign o_wdata = i_wdata << {i_off, 3'b000};

    always_comb begin
        w_byte = i_rword[7:0];
        case (i_off)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];
    end

    always_comb begin
        o_rdata = i_rword;
        case (i_funct3)
            F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_rdata = {24'h000000, w_byte};
            F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_rdata = {16'h0000, w_half};
            default: o_rdata = i_rword;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_st_mis;
    logic w_ld_mis;

    always_comb begin
        w_st_mis = 1'b0;
        case (i_we)
            WE_SH:   w_st_mis = (i_off == 2'd3);
            WE_SW:   w_st_mis = (i_off != 2'd0);
            default: w_st_mis = 1'b0;
        endcase
        w_ld_mis = (i_off != 2'd0);
        case (i_funct3)
            F3_LB, F3_LBU: w_ld_mis = 1'b0;
            F3_LH, F3_LHU: w_ld_mis = i_off[0];
            default:       w_ld_mis = (i_off != 2'd0);
        endcase
    end

    // A store takes priority over a simultaneous load, so its alignment decides.
    assign o_misalign = (|i_we) ? w_st_mis : (i_re & w_ld_mis);
`endif

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder with configurable wait states and pipeline stall.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic [3:0]  data_mem_we_i,
    input  logic        re_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        stall_o
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    logic          w_req;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [31:0]   w_ext;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_rdata_next;
    logic [3:0]    w_lanes;
    logic [3:0]    w_wr_lanes;
    logic          w_unused_addr;

    assign w_req         = re_i | (|data_mem_we_i);
    assign w_idx         = addr_i[AW+1:2];
    assign w_unused_addr = ^addr_i[31:AW+2];
    assign w_rword       = r_mem[w_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;

    dmem_lane_align u_align (
        .i_off      (addr_i[1:0]),
        .i_we       (data_mem_we_i),
        .i_funct3   (funct3_i),
        .i_wdata    (wdata_i),
        .i_rword    (w_rword),
        .o_lanes    (w_lanes),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_ext),
        .i_re       (re_i),
        .o_misalign (w_misalign)
    );

    // A trapped access writes nothing and returns zero.
    assign w_wr_lanes   = w_lanes & {4{~w_misalign}};
    assign w_rdata_next = w_misalign ? 32'd0 : w_ext;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_state_next == ST_RESP) begin
            r_misalign <= w_misalign;
        end
    end

    assign misalign_o = r_misalign & (r_state == ST_RESP);
`else
    dmem_lane_align u_align (
        .i_off    (addr_i[1:0]),
        .i_we     (data_mem_we_i),
        .i_funct3 (funct3_i),
        .i_wdata  (wdata_i),
        .i_rword  (w_rword),
        .o_lanes  (w_lanes),
        .o_wdata  (w_wdata_sh),
        .o_rdata  (w_ext)
    );

    assign w_wr_lanes   = w_lanes;
    assign w_rdata_next = w_ext;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES > 0) begin
                        w_state_next = ST_BUSY;
                        w_cnt_next   = CNT_INIT;
                    end else begin
                        w_state_next = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Captured on entry to RESP, so a store+load returns the pre-write word.
            if (w_state_next == ST_RESP) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && r_state == ST_RESP) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_lanes[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = r_rdata;
    assign ready_o = (r_state == ST_RESP);
    assign stall_o = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no wait states and one with three,
// table vectors, corner sequences, and random accesses against a byte-level memory model.
module tb_dmem_responder;

    localparam logic [3:0]  SB   = 4'b0001;
    localparam logic [3:0]  SH   = 4'b0011;
    localparam logic [3:0]  SW   = 4'b1111;
    localparam logic [2:0]  LB   = 3'b000;
    localparam logic [2:0]  LH   = 3'b001;
    localparam logic [2:0]  LW   = 3'b010;
    localparam logic [2:0]  LBU  = 3'b100;
    localparam logic [2:0]  LHU  = 3'b101;
    localparam logic [31:0] BASE = 32'h200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic [31:0] addr  [2];
    logic [3:0]  we    [2];
    logic        re    [2];
    logic [2:0]  f3    [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        stall [2];
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        mis   [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mdl [2][8];

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst[0]), .addr_i(addr[0]), .data_mem_we_i(we[0]), .re_i(re[0]),
        .funct3_i(f3[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ready_o(ready[0]),
`ifdef DMEM_MISALIGN_TRAP_EN
        .misalign_o(mis[0]),
`endif
        .stall_o(stall[0])
    );

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst_n(rst[1]), .addr_i(addr[1]), .data_mem_we_i(we[1]), .re_i(re[1]),
        .funct3_i(f3[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ready_o(ready[1]),
`ifdef DMEM_MISALIGN_TRAP_EN
        .misalign_o(mis[1]),
`endif
        .stall_o(stall[1])
    );

    typedef struct {
        string       name;
        logic [3:0]  we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-granular memory rules.
    function automatic int ld_size(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int st_size(input logic [3:0] w);
        if (w == SB) return 1;
        if (w == SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [2:0] f, input int off);
        int sz;
        int pos;
        logic [31:0] v;
        sz  = ld_size(f);
        pos = (sz == 1) ? off : ((sz == 2) ? (off / 2) * 2 : 0);
        v   = w >> (8 * pos);
        if (sz == 1) return f[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (sz == 2) return f[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] d,
                                              input int sz, input int off);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < sz; i++) begin
            if (off + i < 4) r[8*(off+i) +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic set_vec(input int i, input string nm, input logic [3:0] w, input logic r,
                           input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                           input logic c, input logic [31:0] e);
        tbl[i].name = nm; tbl[i].we = w; tbl[i].re = r; tbl[i].f3 = f;
        tbl[i].addr = a; tbl[i].wdata = d; tbl[i].chk = c; tbl[i].exp = e;
    endtask

    task automatic do_access(input int k, input logic [3:0] a_we, input logic a_re,
                             input logic [2:0] a_f3, input logic [31:0] a_addr,
                             input logic [31:0] a_wd, input int ws,
                             output logic [31:0] o_rd, output logic o_mis);
        int cyc;
        bit done;
        o_rd  = 32'd0;
        o_mis = 1'b0;
        @(posedge clk); #1;
        we[k] = a_we; re[k] = a_re; f3[k] = a_f3; addr[k] = a_addr; wdata[k] = a_wd;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (ready[k] === 1'b1) begin
                done = 1;
                check32("stall_in_resp", 32'(stall[k]), 32'd0);
                o_rd = rdata[k];
`ifdef DMEM_MISALIGN_TRAP_EN
                o_mis = mis[k];
`endif
            end else begin
                check32("stall_while_wait", 32'(stall[k]), 32'd1);
                @(posedge clk); #1;
                cyc++;
            end
        end
        check32("latency", 32'(cyc), 32'(ws + 1));
        @(posedge clk); #1;
        we[k] = 4'd0; re[k] = 1'b0;
    endtask

    task automatic run_random(input int k, input int ws);
        logic [31:0] rd, a, wd, pre;
        logic        m, is_st, rq;
        logic [3:0]  w;
        logic [2:0]  f;
        int          widx, off;
        bit          smis, lmis;
        for (int i = 0; i < 8; i++) begin
            mdl[k][i] = $urandom;
            do_access(k, SW, 1'b0, LW, BASE + 32'(4 * i), mdl[k][i], ws, rd, m);
        end
        for (int n = 0; n < 60; n++) begin
            widx  = $urandom_range(0, 7);
            off   = $urandom_range(0, 3);
            a     = BASE + 32'(4 * widx + off) + (32'($urandom_range(0, 3)) << 12);
            wd    = $urandom;
            f     = 3'($urandom_range(0, 7));
            is_st = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0:       w = SB;
                1:       w = SH;
                default: w = SW;
            endcase
            if (!is_st) w = 4'd0;
            rq   = is_st ? ($urandom_range(0, 1) == 1) : 1'b1;
            pre  = mdl[k][widx];
            smis = is_st && (off + st_size(w) > 4);
            lmis = rq && ((off % ld_size(f)) != 0);
            do_access(k, w, rq, f, a, wd, ws, rd, m);
`ifdef DMEM_MISALIGN_TRAP_EN
            if (is_st && !smis) mdl[k][widx] = mdl_store(pre, wd, st_size(w), off);
            if (!is_st) check32($sformatf("rand%0d_%0d_rdata", k, n), rd, lmis ? 32'd0 : mdl_load(pre, f, off));
            if (!(is_st && rq && lmis))
                check32($sformatf("rand%0d_%0d_mis", k, n), 32'(m), 32'(is_st ? smis : lmis));
`else
            if (is_st) mdl[k][widx] = mdl_store(pre, wd, st_size(w), off);
            if (!is_st) check32($sformatf("rand%0d_%0d_rdata", k, n), rd, mdl_load(pre, f, off));
`endif
            if (is_st && rq && !smis && !lmis)
                check32($sformatf("rand%0d_%0d_prewrite", k, n), rd, mdl_load(pre, f, off));
        end
        for (int i = 0; i < 8; i++) begin
            do_access(k, 4'd0, 1'b1, LW, BASE + 32'(4 * i), 32'd0, ws, rd, m);
            check32($sformatf("rand%0d_final_w%0d", k, i), rd, mdl[k][i]);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        m;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; addr[k] = 32'd0; we[k] = 4'd0; re[k] = 1'b0;
            f3[k] = LW; wdata[k] = 32'd0;
        end

        set_vec(0,  "sw_10",        SW, 1'b0, LW,     32'h10,   32'hDEADBEEF, 1'b0, 32'h0);
        set_vec(1,  "lw_10",        4'd0, 1'b1, LW,   32'h10,   32'h0,        1'b1, 32'hDEADBEEF);
        set_vec(2,  "sw_10_b",      SW, 1'b0, LW,     32'h10,   32'h11223344, 1'b0, 32'h0);
        set_vec(3,  "sb_13",        SB, 1'b0, LW,     32'h13,   32'h000000AA, 1'b0, 32'h0);
        set_vec(4,  "lw_after_sb",  4'd0, 1'b1, LW,   32'h10,   32'h0,        1'b1, 32'hAA223344);
        set_vec(5,  "lb_13",        4'd0, 1'b1, LB,   32'h13,   32'h0,        1'b1, 32'hFFFFFFAA);
        set_vec(6,  "lbu_13",       4'd0, 1'b1, LBU,  32'h13,   32'h0,        1'b1, 32'h000000AA);
        set_vec(7,  "sw_20_zero",   SW, 1'b0, LW,     32'h20,   32'h0,        1'b0, 32'h0);
        set_vec(8,  "sh_22",        SH, 1'b0, LW,     32'h22,   32'h00008001, 1'b0, 32'h0);
        set_vec(9,  "lw_after_sh",  4'd0, 1'b1, LW,   32'h20,   32'h0,        1'b1, 32'h80010000);
        set_vec(10, "lh_22",        4'd0, 1'b1, LH,   32'h22,   32'h0,        1'b1, 32'hFFFF8001);
        set_vec(11, "lhu_22",       4'd0, 1'b1, LHU,  32'h22,   32'h0,        1'b1, 32'h00008001);
        set_vec(12, "sw_re_prewr",  SW, 1'b1, LW,     32'h20,   32'h12345678, 1'b1, 32'h80010000);
        set_vec(13, "lw111_alias",  4'd0, 1'b1, 3'b111, 32'h1020, 32'h0,      1'b1, 32'h12345678);
        set_vec(14, "lb_21",        4'd0, 1'b1, LB,   32'h21,   32'h0,        1'b1, 32'h00000056);
        set_vec(15, "lhu_20",       4'd0, 1'b1, LHU,  32'h20,   32'h0,        1'b1, 32'h00005678);

        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check32($sformatf("reset_ready%0d", k), 32'(ready[k]), 32'd0);
            check32($sformatf("reset_stall%0d", k), 32'(stall[k]), 32'd0);
            check32($sformatf("reset_rdata%0d", k), rdata[k], 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
            check32($sformatf("reset_mis%0d", k), 32'(mis[k]), 32'd0);
`endif
        end

        for (int i = 0; i < 16; i++) begin
            do_access(0, tbl[i].we, tbl[i].re, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, rd, m);
            if (tbl[i].chk) check32(tbl[i].name, rd, tbl[i].exp);
`ifdef DMEM_MISALIGN_TRAP_EN
            check32({tbl[i].name, "_mis"}, 32'(m), 32'd0);
`endif
        end

        // Misaligned store and load on the zero-wait instance.
        do_access(0, SW, 1'b0, LW, 32'h40, 32'hCAFEF00D, 0, rd, m);
        do_access(0, SW, 1'b0, LW, 32'h42, 32'h9876ABCD, 0, rd, m);
`ifdef DMEM_MISALIGN_TRAP_EN
        check32("sw42_mis", 32'(m), 32'd1);
        do_access(0, 4'd0, 1'b1, LW, 32'h40, 32'h0, 0, rd, m);
        check32("sw42_unchanged", rd, 32'hCAFEF00D);
        do_access(0, 4'd0, 1'b1, LH, 32'h41, 32'h0, 0, rd, m);
        check32("lh41_mis", 32'(m), 32'd1);
        check32("lh41_zero", rd, 32'd0);
`else
        do_access(0, 4'd0, 1'b1, LW, 32'h40, 32'h0, 0, rd, m);
        check32("sw42_partial", rd, 32'hABCDF00D);
        do_access(0, 4'd0, 1'b1, LH, 32'h41, 32'h0, 0, rd, m);
        check32("lh41_inword", rd, 32'hFFFFF00D);
`endif

        // Three wait states: four stalled cycles, ready on the fifth.
        do_access(1, SW, 1'b0, LW, 32'h10, 32'hA5A50F0F, 3, rd, m);
        do_access(1, 4'd0, 1'b1, LW, 32'h10, 32'h0, 3, rd, m);
        check32("ws3_lw", rd, 32'hA5A50F0F);

        // Reset while a store is in BUSY: store dropped, outputs cleared.
        do_access(1, SW, 1'b0, LW, 32'h40, 32'h11111111, 3, rd, m);
        do_access(1, 4'd0, 1'b1, LW, 32'h40, 32'h0, 3, rd, m);
        check32("pre_rst_lw", rd, 32'h11111111);
        @(posedge clk); #1;
        we[1] = SW; re[1] = 1'b0; f3[1] = LW; addr[1] = 32'h40; wdata[1] = 32'h55555555;
        @(posedge clk); #1;
        @(negedge clk);
        check32("busy_stall", 32'(stall[1]), 32'd1);
        @(posedge clk); #1;
        rst[1] = 1'b1; we[1] = 4'd0;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check32("midrst_ready", 32'(ready[1]), 32'd0);
        check32("midrst_stall", 32'(stall[1]), 32'd0);
        check32("midrst_rdata", rdata[1], 32'd0);
        do_access(1, 4'd0, 1'b1, LW, 32'h40, 32'h0, 3, rd, m);
        check32("midrst_mem_kept", rd, 32'h11111111);

        run_random(0, 0);
        run_random(1, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
